// File: rtl/wvb_wr_ctrl_gen2_if.sv
// Waveform-buffer write controller bus: trigger/config inputs, RAM write
// port and event header. The controller attaches as slave, the driving
// logic (trigger path, register file, reader) as master.
interface wvb_wr_if #(
    parameter int P_ADR_WIDTH       = 12,
    parameter int P_LTC_WIDTH       = 48,
    parameter int P_SRC_WIDTH       = 2,
    parameter int P_PRE_CONF_WIDTH  = 5,
    parameter int P_POST_CONF_WIDTH = 8,
    parameter int P_FIX_CONF_WIDTH  = 12
);
    logic                          trig;
    logic [P_SRC_WIDTH-1:0]        trig_src;
    logic [P_LTC_WIDTH-1:0]        ltc;
    logic [P_PRE_CONF_WIDTH-1:0]   pre_config;
    logic [P_POST_CONF_WIDTH-1:0]  post_config;
    logic [P_FIX_CONF_WIDTH-1:0]   fix_config;
    logic [P_ADR_WIDTH-1:0]        max_len_config;
    logic [2**P_SRC_WIDTH-1:0]     fixed_mask;
    logic                          trig_mode;
    logic                          arm;
    logic [P_ADR_WIDTH-1:0]        rd_addr;
    logic                          overflow_clr;

    logic [P_ADR_WIDTH-1:0]        wvb_wr_addr;
    logic                          wvb_wren;
    logic                          hdr_wren;
    logic [P_LTC_WIDTH-1:0]        hdr_evt_ltc;
    logic [P_ADR_WIDTH-1:0]        hdr_start_addr;
    logic [P_ADR_WIDTH-1:0]        hdr_stop_addr;
    logic [P_ADR_WIDTH-1:0]        hdr_evt_len;
    logic [P_SRC_WIDTH-1:0]        hdr_trig_src;
    logic                          hdr_trunc;
    logic                          hdr_ovfl;
    logic [15:0]                   hdr_evt_num;
    logic                          armed;
    logic                          overflow;
    logic                          busy;

    modport slave (
        input  trig, trig_src, ltc, pre_config, post_config, fix_config,
               max_len_config, fixed_mask, trig_mode, arm, rd_addr, overflow_clr,
        output wvb_wr_addr, wvb_wren, hdr_wren, hdr_evt_ltc, hdr_start_addr,
               hdr_stop_addr, hdr_evt_len, hdr_trig_src, hdr_trunc, hdr_ovfl,
               hdr_evt_num, armed, overflow, busy
    );

    modport master (
        output trig, trig_src, ltc, pre_config, post_config, fix_config,
               max_len_config, fixed_mask, trig_mode, arm, rd_addr, overflow_clr,
        input  wvb_wr_addr, wvb_wren, hdr_wren, hdr_evt_ltc, hdr_start_addr,
               hdr_stop_addr, hdr_evt_len, hdr_trig_src, hdr_trunc, hdr_ovfl,
               hdr_evt_num, armed, overflow, busy
    );
endinterface

// File: rtl/wvb_wr_ctrl_gen2.sv
// Second-generation waveform-buffer write controller (one per ADC channel).
// Converts triggers into one-write-per-cycle events with retrigger extension,
// max-length truncation, per-source fixed length and circular-buffer
// overflow detection against the reader pointer.
// Optional feature macro: WVB_EVT_NUM_EN (16-bit header event counter).
//
// state   | meaning
// S_IDLE  | waiting for an accepted trigger; configs sampled here
// S_WIN   | window event: pre+post samples, extended by retriggers
// S_FIXED | fixed-length event: trig ignored until end
module wvb_wr_ctrl_gen2 #(
    parameter int P_ADR_WIDTH       = 12,
    parameter int P_LTC_WIDTH       = 48,
    parameter int P_SRC_WIDTH       = 2,
    parameter int P_PRE_CONF_WIDTH  = 5,
    parameter int P_POST_CONF_WIDTH = 8,
    parameter int P_FIX_CONF_WIDTH  = 12
) (
    input logic    clk,
    input logic    rst_n,
    wvb_wr_if.slave bus
);
    // end index is one bit wider so a retrigger near max length cannot wrap
    localparam int E = P_ADR_WIDTH + 1;
    localparam int N_SRC = 2**P_SRC_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WIN, S_FIXED} state_t;
    state_t r_state, w_state_nxt;

    logic [P_PRE_CONF_WIDTH-1:0]  r_pre;
    logic [P_POST_CONF_WIDTH-1:0] r_post;
    logic [P_FIX_CONF_WIDTH-1:0]  r_fix;
    logic [P_ADR_WIDTH-1:0]       r_max_len;
    logic [N_SRC-1:0]             r_fixed_mask;
    logic [P_ADR_WIDTH-1:0]       r_wr_addr, r_start_addr, r_k;
    logic [E-1:0]                 r_end;
    logic [P_LTC_WIDTH-1:0]       r_ltc;
    logic [P_SRC_WIDTH-1:0]       r_src;
    logic                         r_armed, r_overflow;

    logic                   w_idle, w_full, w_nearly, w_accept, w_fixed_sel;
    logic                   w_wr, w_final, w_trunc, w_max_hit, w_hdr, w_ovf_set;
    logic [P_ADR_WIDTH-1:0] w_addr_p1, w_addr_p2;
    logic [E-1:0]           w_win_len, w_k_e, w_end_eff;

    assign w_idle      = (r_state == S_IDLE);
    assign w_addr_p1   = r_wr_addr + P_ADR_WIDTH'(1);
    assign w_addr_p2   = r_wr_addr + P_ADR_WIDTH'(2);
    assign w_full      = (w_addr_p1 == bus.rd_addr);
    assign w_nearly    = (w_addr_p2 == bus.rd_addr);
    assign w_accept    = w_idle && bus.trig && !r_overflow && (!bus.trig_mode || r_armed);
    assign w_fixed_sel = r_fixed_mask[bus.trig_src];
    assign w_win_len   = E'(r_pre) + E'(r_post) - E'(1);
    assign w_k_e       = E'(r_k);
    assign w_max_hit   = (w_k_e == E'(r_max_len) - E'(1));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_wr && !w_final) w_state_nxt = w_fixed_sel ? S_FIXED : S_WIN;
            S_WIN,
            S_FIXED: if (w_final) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // write / end-index / final decode for the current cycle
    always_comb begin
        w_wr      = 1'b0;
        w_end_eff = r_end;
        case (r_state)
            S_IDLE: begin
                w_wr      = w_accept && !w_full;
                w_end_eff = w_fixed_sel ? (E'(r_fix) - E'(1)) : w_win_len;
            end
            S_WIN: begin
                w_wr = 1'b1;
                if (bus.trig) w_end_eff = w_k_e + w_win_len;
            end
            S_FIXED: w_wr = 1'b1;
            default: w_wr = 1'b0;
        endcase
        w_final = w_wr && (w_nearly || w_max_hit || (w_k_e == w_end_eff));
        w_trunc = w_wr && !w_nearly && w_max_hit && (w_end_eff > w_k_e);
    end

    assign w_hdr     = w_final && rst_n;
    assign w_ovf_set = (w_accept && w_full) || (w_wr && w_nearly);

    // event datapath, config capture, arm and overflow flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0; r_post <= '0; r_fix <= '0; r_max_len <= '0; r_fixed_mask <= '0;
            r_wr_addr <= '0; r_start_addr <= '0; r_k <= '0; r_end <= '0;
            r_ltc <= '0; r_src <= '0; r_armed <= 1'b0; r_overflow <= 1'b0;
        end else begin
            // configs stay frozen from the accepting cycle to the final write
            if (w_idle && !w_wr) begin
                r_pre     <= (bus.pre_config < P_PRE_CONF_WIDTH'(3)) ? P_PRE_CONF_WIDTH'(3) : bus.pre_config;
                r_post    <= (bus.post_config < P_POST_CONF_WIDTH'(2)) ? P_POST_CONF_WIDTH'(2) : bus.post_config;
                r_fix     <= (bus.fix_config < P_FIX_CONF_WIDTH'(3)) ? P_FIX_CONF_WIDTH'(3) : bus.fix_config;
                r_max_len <= (bus.max_len_config < P_ADR_WIDTH'(8)) ? P_ADR_WIDTH'(8) : bus.max_len_config;
                r_fixed_mask <= bus.fixed_mask;
            end
            if (w_wr) begin
                // a nearly-full write lands on rd_addr-2, so +1 leaves it at rd_addr-1
                r_wr_addr <= w_addr_p1;
                r_end     <= w_end_eff;
                r_k       <= w_final ? '0 : r_k + P_ADR_WIDTH'(1);
            end
            if (w_idle && w_wr) begin
                r_start_addr <= r_wr_addr;
                r_ltc        <= bus.ltc;
                r_src        <= bus.trig_src;
            end
            r_armed    <= bus.arm ? 1'b1 : (w_final ? 1'b0 : r_armed);
            r_overflow <= w_ovf_set ? 1'b1 : (bus.overflow_clr ? 1'b0 : r_overflow);
        end
    end

    assign bus.wvb_wr_addr    = r_wr_addr;
    assign bus.wvb_wren       = w_wr && rst_n;
    assign bus.hdr_wren       = w_hdr;
    // a first write can also be final (nearly full), so take live values in S_IDLE
    assign bus.hdr_evt_ltc    = w_hdr ? (w_idle ? bus.ltc : r_ltc) : '0;
    assign bus.hdr_start_addr = w_hdr ? (w_idle ? r_wr_addr : r_start_addr) : '0;
    assign bus.hdr_trig_src   = w_hdr ? (w_idle ? bus.trig_src : r_src) : '0;
    assign bus.hdr_stop_addr  = w_hdr ? r_wr_addr : '0;
    assign bus.hdr_evt_len    = w_hdr ? (r_k + P_ADR_WIDTH'(1)) : '0;
    assign bus.hdr_trunc      = w_hdr && w_trunc;
    assign bus.hdr_ovfl       = w_hdr && w_nearly;
    assign bus.armed          = r_armed;
    assign bus.overflow       = r_overflow;
    assign bus.busy           = !w_idle;

`ifdef WVB_EVT_NUM_EN
    logic [15:0] r_evt_num;

    // event sequence number advances after each header, wrapping at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_evt_num <= '0;
        else if (w_final) r_evt_num <= r_evt_num + 16'd1;
    end

    assign bus.hdr_evt_num = w_hdr ? r_evt_num : '0;
`else
    assign bus.hdr_evt_num = '0;
`endif
endmodule
